exception_ctrl: RTL

- Trap sequencer on the commit side of the ROB. It accepts an exception reported at the ROB head and latches the faulting PC (EPC) and cause.
- It drives the cause to the IVT lookup, flushes the pipeline, then redirects fetch to the IVT-supplied handler address.
- On ERET it redirects fetch to EPC + RETURN_OFFSET. It is the initiator/consumer of the IVT cause→handler interface.

---
 rtl/exc_pkg.sv | 29 ++
 rtl/exception_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared cause encodings, IVT handler addresses and trap-sequencer state type
package exc_pkg;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_DIV0    = 2'b01;
    localparam logic [1:0] CAUSE_LS      = 2'b10;
    localparam logic [1:0] CAUSE_ADDR    = 2'b11;

    localparam logic [15:0] HANDLER_ILLEGAL = 16'h02BC;
    localparam logic [15:0] HANDLER_DIV0    = 16'h030C;
    localparam logic [15:0] HANDLER_LS      = 16'h02E4;
    localparam logic [15:0] HANDLER_ADDR    = 16'h0334;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_RETURN,
        S_HALT
    } state_t;

    function automatic logic [15:0] ivt_lookup(input logic [1:0] cause);
        return cause == CAUSE_ILLEGAL ? HANDLER_ILLEGAL :
               cause == CAUSE_DIV0    ? HANDLER_DIV0    :
               cause == CAUSE_LS      ? HANDLER_LS      : HANDLER_ADDR;
    endfunction

endpackage

// File: rtl/exception_ctrl.sv
// exception_ctrl: commit-side trap sequencer (accept -> flush -> redirect to handler -> ERET return)
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   rob_exc_valid/cause/pc        exception reported at the ROB head
//   eret_valid                    ERET committed
//   ivt_handler_address           combinational IVT answer for ivt_rob_cause
//   ivt_rob_cause                 cause presented to the IVT (= cause_reg)
//   exc_ready                     high only in IDLE
//   flush                         pipeline/ROB flush
//   redirect_valid, redirect_pc   single-cycle fetch redirect
//   epc, cause_reg                latched exception PC and cause
//   in_handler                    handler executing
//   double_fault                  sticky, exception taken while in handler
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int PC_W          = 16,
    parameter int FLUSH_CYCLES  = 2,
    parameter int RETURN_OFFSET = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rob_exc_valid,
    input  logic [1:0]      rob_exc_cause,
    input  logic [PC_W-1:0] rob_exc_pc,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] ivt_handler_address,
    output logic [1:0]      ivt_rob_cause,
    output logic            exc_ready,
    output logic            flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      cause_reg,
    output logic            in_handler,
    output logic            double_fault
);

    state_t          state, next_state;
    logic [3:0]      cnt;
    logic            accept;
    logic            flush_d, redirect_valid_d, in_handler_d;
    logic [PC_W-1:0] redirect_pc_d;

    assign accept        = state == S_IDLE && rob_exc_valid;
    assign exc_ready     = state == S_IDLE;
    assign ivt_rob_cause = cause_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            epc            <= '0;
            cause_reg      <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            in_handler     <= 1'b0;
            double_fault   <= 1'b0;
        end else begin
            state          <= next_state;
            cnt            <= accept ? 4'(FLUSH_CYCLES) : state == S_FLUSH ? cnt - 4'd1 : cnt;
            epc            <= accept ? rob_exc_pc : epc;
            cause_reg      <= accept ? rob_exc_cause : cause_reg;
            flush          <= flush_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            in_handler     <= in_handler_d;
            double_fault   <= double_fault | (next_state == S_HALT);
        end
    end

    // An exception in the handler beats a simultaneous ERET.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     next_state = rob_exc_valid ? S_FLUSH : S_IDLE;
            S_FLUSH:    next_state = cnt == 4'd1 ? S_REDIRECT : S_FLUSH;
            S_REDIRECT: next_state = S_HANDLER;
            S_HANDLER:  next_state = rob_exc_valid ? S_HALT : eret_valid ? S_RETURN : S_HANDLER;
            S_RETURN:   next_state = S_IDLE;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_IDLE;
        endcase
    end

    // Outputs are registered, so they decode the state being entered.
    always_comb begin
        flush_d          = next_state inside {S_FLUSH, S_RETURN, S_HALT};
        redirect_valid_d = next_state inside {S_REDIRECT, S_RETURN};
        in_handler_d     = next_state == S_HANDLER;
        redirect_pc_d    = next_state == S_REDIRECT ? ivt_handler_address :
                           next_state == S_RETURN   ? epc + PC_W'(RETURN_OFFSET) : '0;
    end

endmodule
